hilo_muldiv_unit: RTL and testbench

- Execute-stage responder for the decoder's HI_write/LO_write requests.
- Owns the HI and LO architectural registers and executes MULT, MULTU, DIV, DIVU iteratively over a fixed number of cycles.
- Performs single-cycle MTHI and MTLO writes.
- Continuously presents HI/LO for MFHI/MFLO, and raises a stall request whenever the pipeline touches HI/LO during an operation.

---
 rtl/hilo_muldiv_unit_pkg.sv | 26 ++
 rtl/hilo_iter_core.sv | 62 ++++++
 rtl/hilo_muldiv_unit.sv | 132 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared constants and state encoding for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam logic [1:0] HILO_WR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } hilo_state_e;

  function automatic logic is_signed_op(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
// After W steps: multiply gives {hi_o,lo_o} = a*b; divide gives lo_o = a/b, hi_o = a%b.
module hilo_iter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         div_mode_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] m_q, m_d;
  logic [W:0]   add_sum;
  logic [W:0]   shifted;
  logic         fits;

  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {W{1'b0}})};
    shifted = {hi_q, lo_q[W-1]};
    fits    = shifted >= {1'b0, m_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      m_d  = b_i;
    end else if (step_i) begin
      if (div_mode_i) begin
        // Partial remainder stays below the divisor, so the difference fits in W bits.
        hi_d = fits ? W'(shifted - {1'b0, m_q}) : shifted[W-1:0];
        lo_d = {lo_q[W-2:0], fits};
      end else begin
        hi_d = add_sum[W:1];
        lo_d = {add_sum[0], lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner: MTHI/MTLO writes and iterative MULT/MULTU/DIV/DIVU with stall requests.
// A request is taken only when issue=1 and the unit is IDLE; while busy every issue is dropped
// and stall_req tells the pipeline to hold and re-present it.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [5:0]        funct,
  input  logic [1:0]        hi_write,
  input  logic [1:0]        lo_write,
  input  logic              hilo_read,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              stall_req,
  output hilo_state_e       state_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  hilo_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              busy_q;
  logic              is_div_q;
  logic              div0_q;
  logic              neg_res_q;
  logic              neg_rem_q;

  logic              accept, hi_wr, lo_wr;
  logic              is_mul, is_div, start;
  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic [DATA_W-1:0] core_hi, core_lo;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] hi_fix, lo_fix;

  always_comb begin
    accept = issue && (state_q == IDLE);
    hi_wr  = hi_write == HILO_WR;
    lo_wr  = lo_write == HILO_WR;
    is_mul = (funct == FN_MULT) || (funct == FN_MULTU);
    is_div = (funct == FN_DIV)  || (funct == FN_DIVU);
    start  = accept && hi_wr && lo_wr && (is_mul || is_div);
    rs_neg = is_signed_op(funct) && rs_data[DATA_W-1];
    rt_neg = is_signed_op(funct) && rt_data[DATA_W-1];
    rs_mag = rs_neg ? -rs_data : rs_data;
    rt_mag = rt_neg ? -rt_data : rt_data;
  end

  hilo_iter_core #(.W(DATA_W)) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (start),
    .step_i     ((state_q == MUL) || (state_q == DIV)),
    .div_mode_i (state_q == DIV),
    .a_i        (rs_mag),
    .b_i        (rt_mag),
    .hi_o       (core_hi),
    .lo_o       (core_lo)
  );

  // Divide-by-zero still runs the full loop; the remainder path hands back |rs|, re-signed below.
  always_comb begin
    prod_fix = {core_hi, core_lo};
    if (neg_res_q) prod_fix = -prod_fix;
    if (is_div_q) begin
      lo_fix = div0_q ? {DATA_W{1'b1}} : (neg_res_q ? -core_lo : core_lo);
      hi_fix = neg_rem_q ? -core_hi : core_hi;
    end else begin
      lo_fix = prod_fix[DATA_W-1:0];
      hi_fix = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && funct == FN_MTHI && hi_wr && !lo_wr) begin
            hi_q <= rs_data;
          end else if (accept && funct == FN_MTLO && lo_wr && !hi_wr) begin
            lo_q <= rs_data;
          end else if (start) begin
            state_q   <= is_div ? DIV : MUL;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            is_div_q  <= is_div;
            div0_q    <= is_div && (rt_data == '0);
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
          end
        end
        MUL, DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = busy_q;
  assign state_o   = state_q;
  assign stall_req = busy_q && (hilo_read || (issue && (hi_wr || lo_wr)));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed table-driven bench for hilo_muldiv_unit plus hand sequences for stall, reset and decode corners.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         issue;
  logic [5:0]   funct;
  logic [1:0]   hi_write, lo_write;
  logic         hilo_read;
  logic [W-1:0] rs_data, rt_data;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, stall_req;
  hilo_state_e  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     (issue),
    .funct     (funct),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hilo_read (hilo_read),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .stall_req (stall_req),
    .state_o   (state_o)
  );

  typedef struct {
    logic [5:0]   fn;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    string        name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; the request is presented for exactly one rising edge.
  task automatic issue_op(input logic [5:0] fn, input logic [1:0] hw, input logic [1:0] lw,
                          input logic [W-1:0] rs, input logic [W-1:0] rt);
    issue    = 1'b1;
    funct    = fn;
    hi_write = hw;
    lo_write = lw;
    rs_data  = rs;
    rt_data  = rt;
    @(posedge clk);
    #1;
    issue    = 1'b0;
    funct    = 6'h00;
    hi_write = 2'b00;
    lo_write = 2'b00;
  endtask

  // Counts busy cycles sampled at negedges; returns at the first negedge with busy=0.
  task automatic wait_idle(input string name, output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy_after_%0d_cycles required=idle", name, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = '{FN_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg1x2"};
    vecs[1]  = '{FN_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu_maxx2"};
    vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[3]  = '{FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_by0"};
    vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[5]  = '{FN_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, "multu_3x5"};
    vecs[6]  = '{FN_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu_100_7"};
    vecs[7]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
    vecs[8]  = '{FN_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_m5_by0"};
    vecs[9]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"};
    vecs[10] = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_maxsq"};
    vecs[11] = '{FN_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, "mult_m3_m5"};

    reset_n   = 1'b0;
    issue     = 1'b0;
    funct     = 6'h00;
    hi_write  = 2'b00;
    lo_write  = 2'b00;
    hilo_read = 1'b0;
    rs_data   = '0;
    rt_data   = '0;

    repeat (3) @(negedge clk);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall_req), 32'h0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    // Table runs back to back: each op issues in the first idle cycle after the previous one.
    foreach (vecs[i]) begin
      issue_op(vecs[i].fn, HILO_WR, HILO_WR, vecs[i].rs, vecs[i].rt);
      wait_idle(vecs[i].name, n);
      check($sformatf("%s_busy_cycles", vecs[i].name), 32'(n), 32'(LAT));
      check($sformatf("%s_hi", vecs[i].name), hi_out, vecs[i].exp_hi);
      check($sformatf("%s_lo", vecs[i].name), lo_out, vecs[i].exp_lo);
    end

    issue_op(FN_MTHI, HILO_WR, 2'b00, 32'h00001234, 32'h0);
    @(negedge clk);
    check("mthi_hi", hi_out, 32'h00001234);
    check("mthi_busy", 32'(busy), 32'h0);
    issue_op(FN_MTLO, 2'b01, HILO_WR, 32'h00005678, 32'h0);
    @(negedge clk);
    check("mtlo_lo", lo_out, 32'h00005678);
    check("mtlo_hi_kept", hi_out, 32'h00001234);

    issue_op(FN_MTHI, 2'b01, 2'b00, 32'h00009999, 32'h0);
    @(negedge clk);
    check("mthi_nowr_hi", hi_out, 32'h00001234);
    issue_op(6'h20, HILO_WR, HILO_WR, 32'h1, 32'h2);
    @(negedge clk);
    check("badfn_busy", 32'(busy), 32'h0);
    check("badfn_hi", hi_out, 32'h00001234);
    check("badfn_lo", lo_out, 32'h00005678);

    issue_op(FN_MULT, HILO_WR, HILO_WR, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_stall_idle", 32'(stall_req), 32'h0);
    @(negedge clk);
    hilo_read = 1'b1;
    #1;
    check("mid_stall_read", 32'(stall_req), 32'h1);
    @(negedge clk);
    issue    = 1'b1;
    funct    = FN_MTLO;
    lo_write = HILO_WR;
    rs_data  = 32'hDEADBEEF;
    #1;
    check("mid_stall_mtlo", 32'(stall_req), 32'h1);
    @(negedge clk);
    issue    = 1'b0;
    funct    = 6'h00;
    lo_write = 2'b00;
    check("mid_lo_held", lo_out, 32'h00005678);
    check("mid_hi_held", hi_out, 32'h00001234);
    wait_idle("mid_mult", n);
    check("mid_busy_cycles", 32'(n + 7), 32'(LAT));
    check("mid_stall_after", 32'(stall_req), 32'h0);
    check("mid_res_hi", hi_out, 32'h0);
    check("mid_res_lo", lo_out, 32'd12);
    hilo_read = 1'b0;
    @(negedge clk);
    check("mid_mtlo_dropped", lo_out, 32'd12);

    issue_op(FN_MTHI, HILO_WR, 2'b00, 32'h0000ABCD, 32'h0);
    @(negedge clk);
    issue_op(FN_DIV, HILO_WR, HILO_WR, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_hi", hi_out, 32'h0);
    check("arst_lo", lo_out, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue_op(FN_MULT, HILO_WR, HILO_WR, 32'hFFFFFFFD, 32'd5);
    wait_idle("post_rst_mult", n);
    check("post_rst_busy_cycles", 32'(n), 32'(LAT));
    check("post_rst_hi", hi_out, 32'hFFFFFFFF);
    check("post_rst_lo", lo_out, 32'hFFFFFFF1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
